// File: rtl/eth_payload_buf.sv
// eth_payload_buf: double-buffered UDP payload source for the 10BASE-T
// frame transmitter. One bank fills from a valid/ready producer while the
// other is served to the transmitter at its packet-ROM byte addresses.
// Optional feature macro: ETH_PAYLOAD_SEQ_EN (byte 0 replaced by a frame
// sequence number latched at each bank swap).
module eth_payload_buf #(
    parameter int PAYLOAD_LEN = 18,
    parameter int ADDR_BASE   = 'h32,
    parameter int ADDR_W      = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              tx_busy,
    output logic              start,
    output logic [7:0]        drop_cnt
);

    localparam int LEN_W = $clog2(PAYLOAD_LEN + 1);
    localparam int IDX_W = $clog2(2 * PAYLOAD_LEN);

    typedef enum logic {W_FILL, W_FULL} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ARM, R_SEND} rstate_t;

    wstate_t          wstate, wstate_nxt;
    rstate_t          rstate, rstate_nxt;
    logic             wr_bank;
    logic             rd_bank;
    logic [LEN_W-1:0] wr_ptr;
    logic [LEN_W-1:0] len [2];
    logic [7:0]       mem [0:2*PAYLOAD_LEN-1];

    logic             accept;
    logic             frame_done;
    logic             swap;
    logic             drop;
    int               off;
    logic             in_win;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Saturating byte counter increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign rd_bank = ~wr_bank;

    // Handshake decode, bank addressing and next-state logic for both FSMs.
    always_comb begin
        accept     = s_valid && s_ready;
        drop       = s_valid && !s_ready;
        frame_done = accept && (s_last || (int'(wr_ptr) == PAYLOAD_LEN - 1));
        swap       = (rstate == R_IDLE) && (wstate == W_FULL);
        wstate_nxt = wstate;
        rstate_nxt = rstate;

        off    = int'(rd_addr) - ADDR_BASE;
        in_win = (off >= 0) && (off < PAYLOAD_LEN) && (off < int'(len[rd_bank]));
        wr_idx = IDX_W'(wr_bank ? PAYLOAD_LEN : 0) + IDX_W'(wr_ptr);
        rd_idx = IDX_W'(rd_bank ? PAYLOAD_LEN : 0) + IDX_W'(in_win ? off : 0);

        case (wstate)
            W_FILL:  if (frame_done) wstate_nxt = W_FULL;
            W_FULL:  if (swap)       wstate_nxt = W_FILL;
            default:                 wstate_nxt = W_FILL;
        endcase

        case (rstate)
            R_IDLE:  if (swap)     rstate_nxt = R_ARM;
            R_ARM:   if (tx_busy)  rstate_nxt = R_SEND;
            R_SEND:  if (!tx_busy) rstate_nxt = R_IDLE;
            default:               rstate_nxt = R_IDLE;
        endcase
    end

    // Control state: FSM registers, bank select, fill pointer/lengths, strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate   <= W_FILL;
            rstate   <= R_IDLE;
            s_ready  <= 1'b0;
            start    <= 1'b0;
            drop_cnt <= 8'd0;
            wr_bank  <= 1'b0;
            wr_ptr   <= '0;
            len[0]   <= '0;
            len[1]   <= '0;
        end else begin
            wstate  <= wstate_nxt;
            rstate  <= rstate_nxt;
            s_ready <= (wstate_nxt == W_FILL);
            start   <= swap;
            if (drop) drop_cnt <= sat_inc8(drop_cnt);
            if (accept) wr_ptr <= wr_ptr + LEN_W'(1);
            if (frame_done) len[wr_bank] <= wr_ptr + LEN_W'(1);
            // Accept and swap are exclusive: a swap only happens from FULL.
            if (swap) begin
                wr_bank      <= ~wr_bank;
                len[rd_bank] <= '0;
                wr_ptr       <= '0;
            end
        end
    end

    // Payload storage; contents are meaningless until covered by len.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_idx] <= s_data;
    end

`ifdef ETH_PAYLOAD_SEQ_EN
    logic [7:0] seq;
    logic [7:0] seq_lat;

    // Frame sequence number, captured for the bank being handed to the reader.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq     <= 8'd0;
            seq_lat <= 8'd0;
        end else if (swap) begin
            seq_lat <= seq;
            seq     <= seq + 8'd1;
        end
    end

    // Registered read port; byte 0 carries the sequence number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rd_data <= 8'h00;
        else if (off == 0) rd_data <= seq_lat;
        else if (in_win) rd_data <= mem[rd_idx];
        else             rd_data <= 8'h00;
    end
`else
    // Registered read port; bytes beyond the fill length read as zero padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rd_data <= 8'h00;
        else if (in_win) rd_data <= mem[rd_idx];
        else             rd_data <= 8'h00;
    end
`endif

endmodule

// File: doc/eth_payload_buf.md
Name: eth_payload_buf

Overview:
- Double-buffered UDP payload source that sits directly upstream of the 10BASE-T frame transmitter.
- A producer streams payload bytes in over a valid/ready interface. The block holds one frame being filled while the other is read by the transmitter.
- It serves payload bytes at the transmitter's packet-ROM byte addresses, and it issues the transmit start strobe when a full frame is ready.

Parameters:
- PAYLOAD_LEN, 18: payload bytes per frame; 1..32.
- ADDR_BASE, 7'h32: transmitter byte address of payload byte 0.
- ADDR_W, 7: width of the transmitter byte address.

Ports:
- clk  input  1  system clock (20 MHz transmit clock).
- rst_n  input  1  reset, asynchronous assert, active-low.
- s_data  input  8  payload byte from producer.
- s_valid  input  1  s_data valid.
- s_last  input  1  final byte of the current frame; qualified by s_valid.
- s_ready  output  1  block can accept a byte this cycle.
- rd_addr  input  ADDR_W  transmitter byte address.
- rd_data  output  8  payload byte for rd_addr, registered.
- tx_busy  input  1  transmitter SendingPacket flag.
- start  output  1  one-cycle transmit request.
- drop_cnt  output  8  saturating count of bytes offered while s_ready=0 (s_valid high, s_ready low).

Behaviour:
- Reset values: rst_n low forces all of the following immediately.
  - s_ready=0, rd_data=0, start=0, drop_cnt=0.
  - Both banks empty, both lengths 0, wr_bank=0, rd_bank=1, both FSMs to their initial state.
  - Memory contents are don't-care; reads are masked by length.
  - s_ready rises on the first clk edge after release.
- Storage: two banks of PAYLOAD_LEN x 8 bits, plus a per-bank fill length len[b] of clog2(PAYLOAD_LEN+1) bits.
- Write FSM:
  - FILL: s_ready=1; a byte is accepted when s_valid && s_ready. The byte goes to wr_bank[wr_ptr], then wr_ptr increments.
  - The frame completes on the accepting edge when s_last=1 or wr_ptr==PAYLOAD_LEN-1, whichever comes first. len[wr_bank] is set to the byte count, and the FSM goes to FULL.
  - FULL: s_ready=0; the FSM waits for a swap.
  - A byte offered while s_ready=0 is not stored; drop_cnt increments and saturates at 255.
- Read FSM:
  - IDLE: if the write FSM is in FULL, then on that edge:
    - wr_bank and rd_bank swap;
    - the new wr_bank's len and wr_ptr clear;
    - the write FSM returns to FILL;
    - start is registered high;
    - the read FSM goes to ARM.
  - Latency: if the final byte is accepted at edge N and the read side is IDLE, the swap happens at edge N+1. start is high from N+1 to N+2, and s_ready is low only from N to N+1.
  - ARM: start deasserts after one cycle. Wait for tx_busy=1, then go to SEND.
  - SEND: wait for tx_busy=0, then go to IDLE. rd_bank is stable throughout ARM and SEND.
  - A frame completed while the read side is in ARM or SEND stays in FULL until IDLE. No frame is ever overwritten or dropped.
- Read port, 1-cycle latency:
  - Compute off = rd_addr - ADDR_BASE.
  - If ADDR_BASE <= rd_addr < ADDR_BASE+PAYLOAD_LEN and off < len[rd_bank], then rd_data <= rd_bank[off].
  - Otherwise rd_data <= 8'h00. This covers short frames, which are zero-padded, and addresses outside the payload window.
- Simultaneous events:
  - A write to wr_bank and a read of rd_bank in the same cycle never collide, because the banks are distinct.
  - s_last on byte PAYLOAD_LEN-1 is the same as a length-reached completion.
  - When the swap edge and a new s_valid coincide, that byte is not accepted (s_ready=0) and is counted as a drop.
- Reset mid-frame: everything is discarded, and no start is issued for a partial frame.

Optional Feature:
- ETH_PAYLOAD_SEQ_EN defined:
  - An 8-bit seq register, reset 0, increments on every start pulse.
  - Payload byte 0 (off==0) reads as the value of seq latched at the swap edge, instead of the stored byte. It reads this way even if len[rd_bank]==0.
  - The producer's byte 0 is still accepted and counted in len.
- ETH_PAYLOAD_SEQ_EN undefined: no seq logic; byte 0 reads as stored.

Test Plan:
- Frame fill:
  - Stimulus: after reset, stream 18 bytes 0x00..0x11 with s_valid always high.
  - Response: s_ready drops for one cycle after byte 0x11; start pulses exactly once, 1 cycle later.
  - Stimulus: then sweep rd_addr 0x32..0x43.
  - Response: rd_data equals 0x00..0x11 one cycle after each address; addresses 0x31 and 0x44 return 0x00.
- Short frame: send 5 bytes 0xA0..0xA4 with s_last on 0xA4 -> start pulses; 0x32..0x36 read 0xA0..0xA4; 0x37..0x43 read 0x00.
- Back-to-back frames:
  - Stimulus: complete frame A; hold tx_busy=1 for 1000 cycles; complete frame B during that time.
  - Response: frame B is held in FULL with s_ready=0, and there is no second start while busy.
  - Stimulus: tx_busy falls.
  - Response: start pulses within 2 cycles and the reads return frame B data.
- Overflow: while in FULL, hold s_valid=1 for 300 cycles -> drop_cnt saturates at 255; stored frame unchanged.
- Reset mid-frame: assert rst_n low after 7 of 18 bytes -> s_ready=0, start=0, drop_cnt=0 asynchronously; after release a full fresh frame transmits correctly.
- ETH_PAYLOAD_SEQ_EN: send three frames each starting 0xFF -> byte 0 at rd_addr 0x32 reads 0x00, 0x01, 0x02 on the respective frames.
